// File: rtl/vram_arbiter_pkg.sv
// Shared encodings for the VRAM arbiter: bus width defaults, CPU FSM states,
// grant-source tags and the tag that rides alongside the RAM read pipeline.
package vram_arbiter_pkg;

    localparam int VRAM_AW_DEF        = 13;
    localparam int VRAM_DW_DEF        = 8;
    localparam int VRAM_AGE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_BUSY = 2'd1,
        CPU_DONE = 2'd2
    } cpu_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_src_e;

    // Identifies who owns the word coming back from the RAM two edges later.
    typedef struct packed {
        gnt_src_e src;
        logic     we;
    } gnt_tag_t;

    localparam gnt_tag_t TAG_NONE = '{src: GNT_NONE, we: 1'b0};

    function automatic gnt_tag_t make_tag(input logic vid, input logic cpu, input logic we);
        gnt_tag_t t;
        t = TAG_NONE;
        if (vid) begin
            t.src = GNT_VID;
        end else if (cpu) begin
            t.src = GNT_CPU;
            t.we  = we;
        end
        return t;
    endfunction

endpackage

// File: rtl/vram_arb_age.sv
// Aging guard for the VRAM arbiter: age counter, one-entry pending video slot
// and sticky overrun flag. Compiled only when VRAM_ARB_AGE_EN is defined.
`ifdef VRAM_ARB_AGE_EN
module vram_arb_age
    import vram_arbiter_pkg::*;
#(
    parameter int AW        = VRAM_AW_DEF,
    parameter int AGE_LIMIT = VRAM_AGE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req_i,
    input  logic [AW-1:0] vid_addr_i,
    input  logic          cpu_pending_i,
    output logic          gnt_vid_o,
    output logic          gnt_cpu_o,
    output logic [AW-1:0] gnt_vid_addr_o,
    output logic          overrun_o
);

    localparam int            CW      = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
    localparam logic [CW-1:0] AGE_MAX = CW'(AGE_LIMIT);

    logic [CW-1:0] age_q, age_d;
    logic          slot_valid_q, slot_valid_d;
    logic [AW-1:0] slot_addr_q, slot_addr_d;
    logic          overrun_q, overrun_d;
    logic          vid_any;

    // The pending slot always outranks a fresh request so fetches stay in order.
    assign vid_any        = slot_valid_q || vid_req_i;
    assign gnt_cpu_o      = cpu_pending_i && (!vid_any || (age_q == AGE_MAX));
    assign gnt_vid_o      = vid_any && !gnt_cpu_o;
    assign gnt_vid_addr_o = slot_valid_q ? slot_addr_q : vid_addr_i;
    assign overrun_o      = overrun_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        age_d        = age_q;
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        overrun_d    = overrun_q;

        if (gnt_cpu_o) begin
            age_d = '0;
            if (vid_req_i) begin
                if (slot_valid_q) begin
                    overrun_d = 1'b1;
                end else begin
                    slot_valid_d = 1'b1;
                    slot_addr_d  = vid_addr_i;
                end
            end
        end else begin
            if (slot_valid_q) begin
                slot_valid_d = vid_req_i;
                if (vid_req_i) begin
                    slot_addr_d = vid_addr_i;
                end
            end
            if (cpu_pending_i && (age_q != AGE_MAX)) begin
                age_d = age_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_q        <= '0;
            slot_valid_q <= 1'b0;
            slot_addr_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            age_q        <= age_d;
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule
`endif

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the VGA fetch path and the AVR bus, video first.
// Define VRAM_ARB_AGE_EN to bound CPU wait with the aging guard (vram_arb_age).
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW        = VRAM_AW_DEF,
    parameter int DW        = VRAM_DW_DEF,
    parameter int AGE_LIMIT = VRAM_AGE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    cpu_state_e    state_q, state_d;
    gnt_tag_t      tag_d, tag_s1_q, tag_s2_q;
    logic          cpu_pending;
    logic          gnt_vid, gnt_cpu, overrun;
    logic [AW-1:0] gnt_vid_addr;

    logic          ram_en_q, ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          vid_valid_q, cpu_ack_q;
    logic [DW-1:0] vid_data_q, cpu_rdata_q;

    // Only an IDLE FSM may compete; DONE holds off a still-high cpu_req.
    assign cpu_pending = (state_q == CPU_IDLE) && cpu_req;

`ifdef VRAM_ARB_AGE_EN
    vram_arb_age #(
        .AW        (AW),
        .AGE_LIMIT (AGE_LIMIT)
    ) u_age (
        .clk            (clk),
        .reset          (reset),
        .vid_req_i      (vid_req),
        .vid_addr_i     (vid_addr),
        .cpu_pending_i  (cpu_pending),
        .gnt_vid_o      (gnt_vid),
        .gnt_cpu_o      (gnt_cpu),
        .gnt_vid_addr_o (gnt_vid_addr),
        .overrun_o      (overrun)
    );
`else
    logic age_limit_unused;
    assign age_limit_unused = ^AGE_LIMIT;
    assign gnt_vid          = vid_req;
    assign gnt_vid_addr     = vid_addr;
    assign gnt_cpu          = cpu_pending && !vid_req;
    assign overrun          = 1'b0;
`endif

    assign tag_d = make_tag(gnt_vid, gnt_cpu, cpu_we);

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_IDLE: if (gnt_cpu)                  state_d = CPU_BUSY;
            CPU_BUSY: if (tag_s2_q.src == GNT_CPU)  state_d = CPU_DONE;
            CPU_DONE: if (!cpu_req)                 state_d = CPU_IDLE;
            default:                                state_d = CPU_IDLE;
        endcase
    end

    // Grant edge drives ram_*, the RAM answers one edge later, the result lands one edge after that.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CPU_IDLE;
            tag_s1_q    <= TAG_NONE;
            tag_s2_q    <= TAG_NONE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here see pre-edge values, as real flops do.
            state_q  <= state_d;
            tag_s1_q <= tag_d;
            tag_s2_q <= tag_s1_q;

            ram_en_q <= gnt_vid || gnt_cpu;
            ram_we_q <= gnt_cpu && cpu_we;
            if (gnt_vid) begin
                ram_addr_q <= gnt_vid_addr;
            end else if (gnt_cpu) begin
                ram_addr_q  <= cpu_addr;
                ram_wdata_q <= cpu_wdata;
            end

            vid_valid_q <= (tag_s2_q.src == GNT_VID);
            cpu_ack_q   <= (tag_s2_q.src == GNT_CPU);
            if (tag_s2_q.src == GNT_VID) begin
                vid_data_q <= ram_rdata;
            end
            if ((tag_s2_q.src == GNT_CPU) && !tag_s2_q.we) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign vid_valid   = vid_valid_q;
    assign vid_data    = vid_data_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign vid_overrun = overrun;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model (shadow memory, expected-event queues, aging rules).
module tb_vram_arbiter;

    localparam int AW        = 13;
    localparam int DW        = 8;
    localparam int AGE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          vid_overrun;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .AGE_LIMIT (AGE_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_valid   (vid_valid),
        .vid_data    (vid_data),
        .vid_overrun (vid_overrun),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Synchronous single-port RAM, preloaded with addr[7:0].
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_en === 1'b1) begin
                if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } vid_ev_t;

    logic [DW-1:0] shadow [0:(1<<AW)-1];
    vid_ev_t       vid_exp_q[$];
    int            cyc;
    logic          cpu_open;
    int            cpu_ack_cyc;
    logic          cpu_ack_rd;
    logic [DW-1:0] cpu_ack_data;
    logic          exp_vid_valid, exp_cpu_ack, exp_overrun;
    logic [DW-1:0] exp_vid_data, exp_cpu_rdata;
`ifdef VRAM_ARB_AGE_EN
    int            age;
    logic [AW-1:0] pend_q[$];
`endif

    task automatic model_reset();
        vid_exp_q.delete();
        cpu_open      = 1'b0;
        cpu_ack_cyc   = -1;
        cpu_ack_rd    = 1'b0;
        cpu_ack_data  = '0;
        exp_vid_valid = 1'b0;
        exp_cpu_ack   = 1'b0;
        exp_overrun   = 1'b0;
        exp_vid_data  = '0;
        exp_cpu_rdata = '0;
`ifdef VRAM_ARB_AGE_EN
        age = 0;
        pend_q.delete();
`endif
    endtask

    // One arbitration edge: who gets the RAM, and what comes back two edges later.
    task automatic model_edge();
        logic          cpu_go;
        logic          vid_go;
        logic [AW-1:0] vaddr;
        vid_ev_t       ev;
        cpu_go = 1'b0;
        vid_go = 1'b0;
        vaddr  = '0;
`ifdef VRAM_ARB_AGE_EN
        cpu_go = cpu_open && ((pend_q.size() == 0 && !vid_req) || age == AGE_LIMIT);
        if (cpu_go) begin
            age = 0;
            if (vid_req) begin
                if (pend_q.size() == 0) pend_q.push_back(vid_addr);
                else exp_overrun = 1'b1;
            end
        end else begin
            if (pend_q.size() > 0) begin
                vid_go = 1'b1;
                vaddr  = pend_q.pop_front();
                if (vid_req) pend_q.push_back(vid_addr);
            end else if (vid_req) begin
                vid_go = 1'b1;
                vaddr  = vid_addr;
            end
            if (cpu_open && age < AGE_LIMIT) age++;
        end
`else
        vid_go = vid_req;
        vaddr  = vid_addr;
        cpu_go = cpu_open && !vid_req;
`endif
        if (vid_go) begin
            ev.cyc  = cyc + 2;
            ev.data = shadow[vaddr];
            vid_exp_q.push_back(ev);
        end
        if (cpu_go) begin
            cpu_open    = 1'b0;
            cpu_ack_cyc = cyc + 2;
            cpu_ack_rd  = !cpu_we;
            if (cpu_we) shadow[cpu_addr] = cpu_wdata;
            else cpu_ack_data = shadow[cpu_addr];
        end
    endtask

    // Advance one clock; outputs are sampled on the following falling edge.
    task automatic tick();
        vid_ev_t ev;
        @(posedge clk);
        cyc++;
        if (reset === 1'b1) model_edge();
        @(negedge clk);
        exp_vid_valid = 1'b0;
        if (vid_exp_q.size() > 0 && vid_exp_q[0].cyc == cyc) begin
            ev            = vid_exp_q.pop_front();
            exp_vid_valid = 1'b1;
            exp_vid_data  = ev.data;
        end
        exp_cpu_ack = (cpu_ack_cyc == cyc);
        if (exp_cpu_ack && cpu_ack_rd) exp_cpu_rdata = cpu_ack_data;
    endtask

    task automatic cpu_raise(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_open  = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (cpu_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset     = 1'b0;
        vid_req   = 1'b1;
        vid_addr  = 13'h0055;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h0077;
        cpu_wdata = 8'h3C;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got %h want 0",
                         {vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata});
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            tick();
            total++;
            if ({vid_valid, cpu_ack, ram_en} !== 3'b000) begin
                bad++;
                $display("FAIL reset_release_quiet: valid/ack/en=%b want 000", {vid_valid, cpu_ack, ram_en});
            end
        end
    endtask

    task automatic test_cpu_write_read();
        int lat;
        int acks;
        cpu_raise(1'b1, 13'h0123, 8'hA5);
        tick();
        total++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 13'h0123, 8'hA5}) begin
            bad++;
            $display("FAIL write_ram_drive: got %h want %h", {ram_en, ram_we, ram_addr, ram_wdata},
                     {1'b1, 1'b1, 13'h0123, 8'hA5});
        end
        wait_ack(8, lat);
        total++;
        if (lat != 2) begin
            bad++;
            $display("FAIL write_ack_latency: got %0d want 2 ticks after grant", lat);
        end
        total++;
        if (cpu_rdata !== 8'h00) begin
            bad++;
            $display("FAIL write_keeps_rdata: got %h want 00", cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        cpu_raise(1'b0, 13'h0123, 8'h00);
        wait_ack(8, lat);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL read_ack_latency: got %0d want 3", lat);
        end
        total++;
        if (cpu_rdata !== 8'hA5) begin
            bad++;
            $display("FAIL read_data: got %h want a5", cpu_rdata);
        end
        acks = 0;
        repeat (5) begin
            tick();
            if (cpu_ack === 1'b1) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL held_req_single_ack: extra acks=%0d want 0", acks);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_video_burst();
        int n     = 0;
        int first = -1;
        for (int i = 0; i < 12; i++) begin
            vid_req  = (i < 8);
            vid_addr = AW'(i);
            tick();
            if (vid_valid === 1'b1) begin
                total++;
                if (vid_data !== DW'(n) || i != n + 2) begin
                    bad++;
                    $display("FAIL burst_data: tick %0d got %h want %h at tick %0d", i, vid_data, DW'(n), n + 2);
                end
                if (first < 0) first = i;
                n++;
            end
        end
        total++;
        if (n != 8 || first != 2) begin
            bad++;
            $display("FAIL burst_count: got %0d pulses first at %0d, want 8 first at 2", n, first);
        end
    endtask

    task automatic test_conflict();
        int            vid_tick = -1;
        int            ack_tick = -1;
        logic [DW-1:0] rd       = '0;
        logic [DW-1:0] vd       = '0;
        vid_req  = 1'b1;
        vid_addr = 13'h0005;
        cpu_raise(1'b0, 13'h0010, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            tick();
            vid_req = 1'b0;
            if (vid_valid === 1'b1 && vid_tick < 0) begin
                vid_tick = i;
                vd       = vid_data;
            end
            if (cpu_ack === 1'b1 && ack_tick < 0) begin
                ack_tick = i;
                rd       = cpu_rdata;
                cpu_req  = 1'b0;
            end
        end
        total++;
        if (vid_tick != 3 || vd !== 8'h05) begin
            bad++;
            $display("FAIL conflict_video: tick %0d data %h, want tick 3 data 05", vid_tick, vd);
        end
        total++;
        if (ack_tick != 4 || rd !== 8'h10) begin
            bad++;
            $display("FAIL conflict_cpu: tick %0d data %h, want tick 4 data 10", ack_tick, rd);
        end
    endtask

`ifdef VRAM_ARB_AGE_EN
    task automatic test_priority();
        int            ack_tick = -1;
        int            n        = 0;
        int            late     = -1;
        logic [DW-1:0] rd       = '0;
        cpu_raise(1'b0, 13'h0020, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            vid_req  = (i <= 16);
            vid_addr = AW'(13'h0040 + i - 1);
            tick();
            if (vid_valid === 1'b1) begin
                total++;
                if (vid_data !== DW'(8'h40 + n)) begin
                    bad++;
                    $display("FAIL aging_order: got %h want %h", vid_data, DW'(8'h40 + n));
                end
                if (n == 4) late = i;
                n++;
            end
            if (cpu_ack === 1'b1 && ack_tick < 0) begin
                ack_tick = i;
                rd       = cpu_rdata;
                cpu_req  = 1'b0;
            end
        end
        total++;
        if (ack_tick != 7 || rd !== 8'h20) begin
            bad++;
            $display("FAIL aging_cpu_grant: ack tick %0d data %h, want tick 7 data 20", ack_tick, rd);
        end
        total++;
        if (late != 8 || n != 16) begin
            bad++;
            $display("FAIL aging_displaced: fetch 4 at tick %0d count %0d, want tick 8 count 16", late, n);
        end
        total++;
        if (vid_overrun !== 1'b0) begin
            bad++;
            $display("FAIL aging_no_overrun: got %b want 0", vid_overrun);
        end
    endtask
`else
    task automatic test_priority();
        int acks = 0;
        int lat;
        cpu_raise(1'b0, 13'h0020, 8'h00);
        for (int i = 0; i < 20; i++) begin
            vid_req  = 1'b1;
            vid_addr = AW'(13'h0040 + i);
            tick();
            if (cpu_ack === 1'b1) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL starve_no_ack: got %0d acks want 0", acks);
        end
        vid_req = 1'b0;
        wait_ack(8, lat);
        total++;
        if (lat != 3 || cpu_rdata !== 8'h20) begin
            bad++;
            $display("FAIL starve_release: lat %0d data %h, want 3 and 20", lat, cpu_rdata);
        end
        cpu_req = 1'b0;
        repeat (2) tick();
    endtask
`endif

    task automatic test_reset_busy();
        int acks = 0;
        int lat;
        cpu_raise(1'b0, 13'h0123, 8'h00);
        tick();
        reset = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) acks++;
        end
        cpu_req = 1'b0;
        reset   = 1'b1;
        repeat (3) begin
            tick();
            if (cpu_ack === 1'b1 || vid_valid === 1'b1) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL reset_busy_no_ack: got %0d stray pulses want 0", acks);
        end
        cpu_raise(1'b0, 13'h0123, 8'h00);
        wait_ack(8, lat);
        total++;
        if (lat != 3 || cpu_rdata !== 8'hA5) begin
            bad++;
            $display("FAIL reset_busy_recover: lat %0d data %h, want 3 and a5", lat, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int low = 1;
        for (int i = 0; i < 400; i++) begin
            vid_req  = ($urandom_range(0, 99) < 55);
            vid_addr = AW'($urandom_range(0, 63));
            if (cpu_req == 1'b0 && low >= 1 && $urandom_range(0, 3) == 0)
                cpu_raise(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom_range(0, 255)));
            tick();
            total++;
            if (vid_valid !== exp_vid_valid || vid_data !== exp_vid_data) begin
                bad++;
                $display("FAIL rand_video @%0d: got valid=%b data=%h want valid=%b data=%h",
                         i, vid_valid, vid_data, exp_vid_valid, exp_vid_data);
            end
            total++;
            if (cpu_ack !== exp_cpu_ack || cpu_rdata !== exp_cpu_rdata) begin
                bad++;
                $display("FAIL rand_cpu @%0d: got ack=%b rdata=%h want ack=%b rdata=%h",
                         i, cpu_ack, cpu_rdata, exp_cpu_ack, exp_cpu_rdata);
            end
            total++;
            if (vid_overrun !== exp_overrun) begin
                bad++;
                $display("FAIL rand_overrun @%0d: got %b want %b", i, vid_overrun, exp_overrun);
            end
            if (cpu_ack === 1'b1) begin
                cpu_req = 1'b0;
                low     = 0;
            end else if (cpu_req == 1'b0) begin
                low++;
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) shadow[i] = DW'(i);
        cyc = 0;
        model_reset();
        test_reset();
        test_cpu_write_read();
        test_video_burst();
        test_conflict();
        test_priority();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
